hexkey_scan: RTL and testbench
==============================

Name: hexkey_scan

Overview:
- Input-side counterpart of the 4-digit hex display driver: scans a 4x4 hex keypad matrix, debounces presses, and emits a 4-bit key code with a one-cycle strobe.
- Keeps a 16-bit entry word that shifts in each new nibble at the LSB end. The word is wired to the display driver so typed digits scroll onto the display.
- Shares the display's clken scan tick, roughly 1 kHz.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive clken samples needed to accept a press and to accept a release. Legal range 2..15.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- clken  in  1  one-clk scan tick; all scan/debounce state advances only when high
- clear  in  1  synchronous; zeroes word
- col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- row_n  out  4  keypad row drive, active-low, exactly one bit low at all times
- key  out  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}
- key_valid  out  1  one-clk pulse when a debounced press is accepted
- key_down  out  1  high while the accepted key is held or its release is being debounced
- word  out  16  entry register, newest nibble in [3:0]

Behaviour:
- Reset values (asynchronous): row_n=4'b1110 (row 0), key=0, key_valid=0, key_down=0, word=0, state=SCAN, cnt=0, synchronizer flops=4'b1111.
- col_n passes through a 2-flop synchronizer clocked every clk; only synchronized cols (cs_n) are used.
- Row r drive: row_n[r]=0, all other bits 1. Row changes only on a clken tick, so cols settle for a full tick before they are sampled.
- All transitions below happen only on cycles with clken=1. key_valid is registered and high for exactly the one clk after the accepting tick.
- SCAN:
  - cs_n==4'b1111: advance row index, r -> r+1 mod 4 (3 wraps to 0).
  - Any bit low: latch cand = {r, c}, where c is the lowest-index low column. Hold the row. Set cnt=1 and go to DEBOUNCE.
- DEBOUNCE (row held):
  - The lowest-index low column still equals cand col:
    - If cnt==DEBOUNCE_TICKS-1: set key=cand, pulse key_valid, shift word, go to HELD.
    - Otherwise: cnt++.
  - Otherwise (released or a different column): go to SCAN and advance the row. No strobe.
- HELD (row held):
  - cand column high: cnt=1, go to RELEASE.
  - Otherwise stay. Auto-repeat is not generated.
- RELEASE (row held):
  - cand column high:
    - If cnt==DEBOUNCE_TICKS-1: go to SCAN and advance the row.
    - Otherwise: cnt++.
  - cand column low: go back to HELD. No new strobe, since a bounce is not a new press.
- key_down=1 exactly when state is HELD or RELEASE (registered with state).
- Multiple keys:
  - Within a row, the lowest column index wins.
  - Keys on other rows are invisible while a row is held.
  - Another column pressed in the held row during HELD is ignored.
- Word update on accept: word <= {word[11:0], cand}.
  - clear in the same clk as an accept wins: word=0 and the nibble is dropped. key and key_valid still update.
  - clear acts regardless of clken.
- clken=0 forever: state, row, and cnt are frozen. The synchronizer still runs.
- reset mid-press: immediate return to reset values. A key still held after release of reset is re-detected and re-debounced from SCAN, producing a fresh strobe.
- cnt width is 4 bits. No arithmetic other than cnt++ and row++ (both wrap-safe within their ranges).

Decomposition:
- Package hexkey_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - KEY_W=4, ROWS=4, COLS=4
  - function lowest_low_col(cs_n) returning a found flag plus a 2-bit index
- Sub-module sync2 (parameterized width, 2-flop synchronizer, async reset to all-ones), instantiated once for col_n.

Test Plan:
All scenarios use DEBOUNCE_TICKS=4 and clken every 4th clk.
- Idle, no key: row_n cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110 one step per tick. key_valid never high; word stays 0.
- Clean press of row 2 / col 1 (col_n[1] low whenever row_n[2]=0), held for 20 ticks:
  - exactly one key_valid pulse, key=4'h9, word=16'h0009
  - key_down high until 4 high ticks after release, then scanning resumes
- Bounce: col low for 2 ticks, high for 1, low thereafter → no strobe on the first burst; one strobe after 4 stable ticks. Release bounce of 2 ticks → no second strobe.
- Keys 1, 2, 3, A, F entered in sequence, each with a clean press/release → word = 16'h23AF (oldest nibble shifted out), with five key_valid pulses.
- Two columns held in row 0 (cols 2 and 3) → key=4'h2 only. clear asserted in the same clk as a key_valid → word=0, key updated.
- Async reset asserted during DEBOUNCE with the key held:
  - outputs return to reset values immediately, row_n=1110
  - after deassert, the held key is strobed once after a full re-debounce

Source files
------------

// File: rtl/hexkey_pkg.sv
// hexkey_pkg: shared types and helpers for the hex keypad scanner.
//   state_t        scanner FSM states
//   KEY_W/ROWS/COLS keypad geometry
//   col_hit_t      result of a column search (found flag + column index)
//   lowest_low_col returns the lowest-index active-low column of a sample
package hexkey_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } col_hit_t;

    // Walk from the top column down so the lowest low column is the last
    // one written and therefore wins.
    function automatic col_hit_t lowest_low_col(input logic [COLS-1:0] cs_n);
        col_hit_t hit;
        hit = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                hit.found = 1'b1;
                hit.idx   = i[1:0];
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/hexkey_if.sv
// hexkey_if: keypad matrix lines plus the key/entry-word outputs of the
// scanner, bundled for connection to the display side.
//   col_n     keypad columns, active-low (toward scanner)
//   row_n     keypad row drive, active-low (from scanner)
//   key       last accepted key code {row_idx, col_idx}
//   key_valid one-clk strobe on acceptance
//   key_down  accepted key held / release being debounced
//   word      16-bit entry word, newest nibble in [3:0]
//   clear     synchronous clear of word (toward scanner)
//
// Handshake: key_valid is a pure strobe with no ready/backpressure. It is
// high for exactly one clk, and key is stable from that clk until the next
// strobe; a consumer must sample key in the cycle key_valid is high or later.
interface hexkey_if;
    import hexkey_pkg::*;

    logic [COLS-1:0]    col_n;
    logic [ROWS-1:0]    row_n;
    logic [KEY_W-1:0]   key;
    logic               key_valid;
    logic               key_down;
    logic [4*KEY_W-1:0] word;
    logic               clear;

    modport master (
        input  col_n, clear,
        output row_n, key, key_valid, key_down, word
    );

    modport slave (
        output col_n, clear,
        input  row_n, key, key_valid, key_down, word
    );

endinterface

// File: rtl/hexkey_scan_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs.
//   clk   system clock
//   reset asynchronous active-high reset; flops go to all-ones (idle pull-up)
//   d_i   asynchronous input bus
//   q_o   synchronized output bus
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hexkey_scan.sv
// hexkey_scan: 4x4 hex keypad scanner with press/release debounce and a
// 16-bit entry word that scrolls in each accepted key nibble.
//   clk         system clock
//   reset       asynchronous active-high reset
//   clken       scan tick; FSM, row and counter advance only when high
//   bus         hexkey_if master: col_n/clear in, row_n/key/key_valid/
//               key_down/word out
//   dbg_state_o current FSM state
module hexkey_scan
    import hexkey_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clken,
    hexkey_if.master bus,
    output state_t   dbg_state_o
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_TICKS - 1);

    logic [COLS-1:0] cs_n;

    state_t             state_q, state_d;
    logic [1:0]         row_q, row_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [KEY_W-1:0]   cand_q, cand_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic [4*KEY_W-1:0] word_q, word_d;

    col_hit_t hit;
    logic     cand_high;

    sync2 #(.WIDTH(COLS)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.col_n),
        .q_o   (cs_n)
    );

    assign hit       = lowest_low_col(cs_n);
    // Only the candidate's own column matters once a row is held.
    assign cand_high = cs_n[cand_q[1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            row_q       <= 2'd0;
            cnt_q       <= 4'd0;
            cand_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            word_q      <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        word_d      = word_q;

        if (clken) begin
            unique case (state_q)
                SCAN: begin
                    if (hit.found) begin
                        cand_d  = {row_q, hit.idx};
                        cnt_d   = 4'd1;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit.found && (hit.idx == cand_q[1:0])) begin
                        if (cnt_q == CNT_LAST) begin
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            word_d      = {word_q[4*KEY_W-5:0], cand_q};
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        // Released or shifted to another column: abandon.
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                    end
                end
                HELD: begin
                    if (cand_high) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (cand_high) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        // Release bounce: same key, no new strobe.
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        // clear is not gated by clken and drops a same-cycle nibble.
        if (bus.clear) begin
            word_d = '0;
        end
    end

    assign bus.row_n     = ~(4'b0001 << row_q);
    assign bus.key       = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_down  = (state_q == HELD) || (state_q == RELEASE);
    assign bus.word      = word_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hexkey_scan.sv
module tb_hexkey_scan;
    import hexkey_pkg::*;

    logic   clk;
    logic   reset;
    logic   clken;
    state_t dbg_state;
    logic [15:0] pressed;   // pressed[r*4+c] = key at row r, column c held

    int total;
    int bad;
    int strobes;
    int exp_strobes;

    hexkey_if kif ();

    hexkey_scan #(.DEBOUNCE_TICKS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .bus         (kif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / tick / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clken = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            clken = 1'b1;
            @(negedge clk);
            clken = 1'b0;
        end
    end

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        kif.col_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
            end
        end
    end

    // Strobe monitor, sampled 1 ns after each rising edge.
    initial begin
        strobes = 0;
        forever begin
            @(posedge clk);
            #1;
            if (kif.key_valid === 1'b1) strobes++;
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 2 ns after the next rising edge on which clken was high.
    task automatic next_tick();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (!clken && g < 10);
    endtask

    task automatic wait_state(input string tag, input state_t s, input int max_ticks);
        int n;
        n = 0;
        while (dbg_state !== s && n < max_ticks) begin
            next_tick();
            n++;
        end
        check(tag, 16'(dbg_state), 16'(s));
    endtask

    task automatic wait_strobe(input string tag, input int want, input int max_ticks);
        int n;
        n = 0;
        while (strobes < want && n < max_ticks) begin
            next_tick();
            n++;
        end
        check(tag, 16'(strobes), 16'(want));
    endtask

    task automatic press_release(input int idx, input logic [3:0] exp_key);
        pressed[idx] = 1'b1;
        exp_strobes++;
        wait_strobe("seq_strobe", exp_strobes, 12);
        check("seq_key", 16'(kif.key), 16'(exp_key));
        pressed[idx] = 1'b0;
        repeat (6) next_tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] idle_seq [4];
        total       = 0;
        bad         = 0;
        exp_strobes = 0;
        pressed     = '0;
        kif.clear   = 1'b0;
        reset       = 1'b1;
        idle_seq[0] = 4'b1101;
        idle_seq[1] = 4'b1011;
        idle_seq[2] = 4'b0111;
        idle_seq[3] = 4'b1110;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_row_n",     16'(kif.row_n),     16'h000E);
        check("rst_key",       16'(kif.key),       16'h0000);
        check("rst_key_valid", 16'(kif.key_valid), 16'h0000);
        check("rst_key_down",  16'(kif.key_down),  16'h0000);
        check("rst_word",      kif.word,           16'h0000);
        check("rst_state",     16'(dbg_state),     16'(SCAN));
        reset = 1'b0;

        // Idle scan rotation
        for (int i = 0; i < 8 && kif.row_n !== 4'b1110; i++) next_tick();
        check("idle_sync", 16'(kif.row_n), 16'h000E);
        for (int i = 0; i < 4; i++) begin
            next_tick();
            check("idle_row_n", 16'(kif.row_n), 16'(idle_seq[i]));
        end
        check("idle_strobes", 16'(strobes), 16'd0);
        check("idle_word", kif.word, 16'h0000);

        // Clean press row 2 / col 1, held 20 ticks
        pressed[9] = 1'b1;
        repeat (20) next_tick();
        exp_strobes++;
        check("press_strobes",  16'(strobes),      16'(exp_strobes));
        check("press_key",      16'(kif.key),      16'h0009);
        check("press_word",     kif.word,          16'h0009);
        check("press_key_down", 16'(kif.key_down), 16'h0001);
        pressed[9] = 1'b0;
        repeat (3) next_tick();
        check("rel3_key_down", 16'(kif.key_down), 16'h0001);
        next_tick();
        check("rel4_key_down", 16'(kif.key_down), 16'h0000);
        check("rel4_row_n",    16'(kif.row_n),    16'h0007);

        // Press bounce on row 1 / col 3: 2 low ticks, 1 high, then low
        pressed[7] = 1'b1;
        wait_state("bounce_detect", DEBOUNCE, 8);
        next_tick();
        pressed[7] = 1'b0;
        next_tick();
        check("bounce_state",   16'(dbg_state),   16'(SCAN));
        check("bounce_strobes", 16'(strobes),     16'(exp_strobes));
        check("bounce_row_n",   16'(kif.row_n),   16'h000B);
        pressed[7] = 1'b1;
        exp_strobes++;
        wait_strobe("bounce_strobe", exp_strobes, 12);
        check("bounce_key",  16'(kif.key), 16'h0007);
        check("bounce_word", kif.word,      16'h0097);

        // Release bounce: high for 2 ticks then low again
        pressed[7] = 1'b0;
        next_tick();
        next_tick();
        check("relb_state", 16'(dbg_state), 16'(RELEASE));
        pressed[7] = 1'b1;
        next_tick();
        check("relb_held",    16'(dbg_state), 16'(HELD));
        check("relb_strobes", 16'(strobes),   16'(exp_strobes));
        pressed[7] = 1'b0;
        repeat (6) next_tick();
        check("relb_done", 16'(dbg_state), 16'(SCAN));

        // Keys 1, 2, 3, A, F in sequence
        press_release(1, 4'h1);
        press_release(2, 4'h2);
        press_release(3, 4'h3);
        press_release(10, 4'hA);
        press_release(15, 4'hF);
        check("seq_word",    kif.word,      16'h23AF);
        check("seq_strobes", 16'(strobes),  16'(exp_strobes));

        // Two columns in row 0: lowest column wins
        pressed[2] = 1'b1;
        pressed[3] = 1'b1;
        exp_strobes++;
        wait_strobe("two_col_strobe", exp_strobes, 12);
        check("two_col_key",  16'(kif.key), 16'h0002);
        check("two_col_word", kif.word,     16'h3AF2);
        pressed[2] = 1'b0;
        pressed[3] = 1'b0;
        repeat (6) next_tick();

        // clear in the same clk as the accept (row 1 / col 0 -> key 4)
        pressed[4] = 1'b1;
        wait_state("clr_detect", DEBOUNCE, 8);
        next_tick();
        next_tick();
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        kif.clear = 1'b1;
        @(posedge clk);
        #2;
        kif.clear = 1'b0;
        exp_strobes++;
        check("clr_key_valid", 16'(kif.key_valid), 16'h0001);
        check("clr_key",       16'(kif.key),       16'h0004);
        check("clr_word",      kif.word,           16'h0000);
        @(posedge clk);
        #2;
        check("clr_pulse_end", 16'(kif.key_valid), 16'h0000);
        check("clr_strobes",   16'(strobes),       16'(exp_strobes));
        pressed[4] = 1'b0;
        repeat (6) next_tick();

        // Async reset during DEBOUNCE with row 3 / col 0 held
        pressed[12] = 1'b1;
        wait_state("ar_detect", DEBOUNCE, 8);
        next_tick();
        #1;
        reset = 1'b1;
        #1;
        check("ar_row_n",    16'(kif.row_n),    16'h000E);
        check("ar_key",      16'(kif.key),      16'h0000);
        check("ar_key_down", 16'(kif.key_down), 16'h0000);
        check("ar_word",     kif.word,          16'h0000);
        check("ar_state",    16'(dbg_state),    16'(SCAN));
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        repeat (5) next_tick();
        check("ar_no_early", 16'(strobes),   16'(exp_strobes));
        check("ar_debounce", 16'(dbg_state), 16'(DEBOUNCE));
        exp_strobes++;
        wait_strobe("ar_strobe", exp_strobes, 12);
        check("ar_key2",  16'(kif.key), 16'h000C);
        check("ar_word2", kif.word,     16'h000C);
        pressed[12] = 1'b0;
        repeat (6) next_tick();
        check("final_strobes", 16'(strobes), 16'(exp_strobes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
